interrupt_unit: RTL and testbench

- Upstream control block for the fetch stage: turns an asynchronous external interrupt request into the single-cycle interrupt pulse consumed by the fetch stage's interrupt input.
- Latches requests and waits until no branch or PC push/pop is in flight in EXM.
- Injects the interrupt with a fetch/decode flush, then blocks re-entry until the handler's return completes plus a hold-off window.

---
 rtl/interrupt_unit.sv | 145 ++++++++++++++
 tb/tb_interrupt_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_unit.sv
// Interrupt request conditioner for the fetch stage: edge-detects requests, waits for EXM to drain,
// issues a one-cycle interrupt/flush and blocks re-entry until return plus hold-off. Optional macro: INTERRUPT_UNIT_SYNC_EN.
module interrupt_unit #(
    parameter int unsigned HOLDOFF     = 2,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_int_req,
    input  logic                   i_int_enable,
    input  logic                   i_pipe_busy,
    input  logic                   i_rti_done,
    output logic                   o_interrupt,
    output logic                   o_flush_f_d,
    output logic                   o_int_active,
    output logic                   o_pending,
    output logic [COUNT_WIDTH-1:0] o_int_count
);

    localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_INJECT,
        S_SERVICE,
        S_HOLDOFF
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_req_s;
    logic                   r_req_d;
    logic                   w_edge;
    logic                   r_pending;
    logic [HW-1:0]          r_hold_cnt;
    logic [COUNT_WIDTH-1:0] r_count;

`ifdef INTERRUPT_UNIT_SYNC_EN
    logic r_sync_meta;
    logic r_sync_out;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync_meta <= 1'b0;
            r_sync_out  <= 1'b0;
        end else begin
            r_sync_meta <= i_int_req;
            r_sync_out  <= r_sync_meta;
        end
    end

    assign w_req_s = r_sync_out;
`else
    assign w_req_s = i_int_req;
`endif

    assign w_edge = w_req_s & ~r_req_d;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_req_d <= 1'b0;
        end else begin
            r_req_d <= w_req_s;
        end
    end

    // A fresh edge in the INJECT cycle wins over the clear, so it is not lost.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pending <= 1'b0;
        end else if (w_edge) begin
            r_pending <= 1'b1;
        end else if (r_state == S_INJECT) begin
            r_pending <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_pending | w_edge) & i_int_enable) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!i_int_enable) begin
                    w_next_state = S_IDLE;
                end else if (!i_pipe_busy) begin
                    w_next_state = S_INJECT;
                end
            end
            S_INJECT: begin
                w_next_state = S_SERVICE;
            end
            S_SERVICE: begin
                if (i_rti_done) begin
                    w_next_state = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (r_hold_cnt <= HW'(1)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hold_cnt <= '0;
        end else if ((r_state == S_SERVICE) && i_rti_done) begin
            r_hold_cnt <= HW'(HOLDOFF);
        end else if ((r_state == S_HOLDOFF) && (r_hold_cnt != '0)) begin
            r_hold_cnt <= r_hold_cnt - HW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (r_state == S_INJECT) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign o_interrupt  = (r_state == S_INJECT);
    assign o_flush_f_d  = (r_state == S_INJECT);
    assign o_int_active = (r_state == S_INJECT) || (r_state == S_SERVICE);
    assign o_pending    = r_pending;
    assign o_int_count  = r_count;

endmodule

// File: tb/tb_interrupt_unit.sv
// Directed bench for interrupt_unit (HOLDOFF=2, COUNT_WIDTH=8); latency adapts to INTERRUPT_UNIT_SYNC_EN.
module tb_interrupt_unit;

`ifdef INTERRUPT_UNIT_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       en;
    logic       busy;
    logic       rti;
    logic       intr;
    logic       flush;
    logic       active;
    logic       pend;
    logic [7:0] cnt;

    int n_checks = 0;
    int n_err    = 0;

    interrupt_unit #(.HOLDOFF(2), .COUNT_WIDTH(8)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_int_req    (req),
        .i_int_enable (en),
        .i_pipe_busy  (busy),
        .i_rti_done   (rti),
        .o_interrupt  (intr),
        .o_flush_f_d  (flush),
        .o_int_active (active),
        .o_pending    (pend),
        .o_int_count  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full interrupt round trip from IDLE back to IDLE, request left low.
    task automatic do_int();
        req = 1'b1;
        repeat (L + 3) tick();
        req = 1'b0;
        rti = 1'b1;
        tick();
        rti = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; en = 1'b1; busy = 1'b0; rti = 1'b0;
        repeat (3) tick();
        check("rst_intr",   intr,   0);
        check("rst_flush",  flush,  0);
        check("rst_active", active, 0);
        check("rst_pend",   pend,   0);
        check("rst_cnt",    cnt,    0);
        rst_n = 1'b1;
        tick();

        // Basic request, held high: one interrupt only
        req = 1'b1;
        for (int i = 0; i < L + 1; i++) begin
            tick();
            check("t1_no_early_intr", intr, 0);
        end
        check("t1_pend_drain", pend, 1);
        tick();
        check("t1_intr",   intr,   1);
        check("t1_flush",  flush,  1);
        check("t1_active", active, 1);
        check("t1_cnt_in", cnt,    0);
        tick();
        check("t1_intr_off", intr,   0);
        check("t1_flush_off", flush, 0);
        check("t1_svc_act",  active, 1);
        check("t1_cnt",      cnt,    1);
        check("t1_pend_clr", pend,   0);
        repeat (3) tick();
        check("t1_svc_hold", active, 1);
        rti = 1'b1;
        tick();
        rti = 1'b0;
        check("t1_hold_act", active, 0);
        repeat (5) begin
            tick();
            check("t1_held_no_int", intr, 0);
        end
        rti = 1'b1;
        tick();
        rti = 1'b0;
        tick();
        check("t1_spurious_rti", active, 0);
        check("t1_cnt_keep", cnt, 1);
        req = 1'b0;
        repeat (3) tick();

        // Busy pipe holds DRAIN for exactly 5 extra cycles
        busy = 1'b1;
        req  = 1'b1;
        repeat (L + 1) tick();
        check("t2_pend_drain", pend, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_busy_no_int", intr, 0);
            check("t2_busy_pend", pend, 1);
        end
        busy = 1'b0;
        tick();
        check("t2_intr", intr, 1);
        req = 1'b0;
        tick();
        check("t2_cnt", cnt, 2);
        rti = 1'b1; tick(); rti = 1'b0;
        tick(); tick();

        // Second edge during SERVICE, taken 4 cycles after return
        req = 1'b1;
        repeat (L + 2) tick();
        check("t3_intr1", intr, 1);
        tick();
        check("t3_cnt1", cnt, 3);
        req = 1'b0;
        tick();
        req = 1'b1;
        repeat (L + 1) tick();
        check("t3_pend_svc", pend, 1);
        check("t3_no_nest", intr, 0);
        check("t3_svc_act", active, 1);
        req = 1'b0;
        rti = 1'b1;
        tick();
        rti = 1'b0;
        check("t3_r0_int", intr, 0);
        check("t3_r0_act", active, 0);
        check("t3_r0_pend", pend, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("t3_hold_no_int", intr, 0);
        end
        tick();
        check("t3_intr2", intr, 1);
        tick();
        check("t3_cnt2", cnt, 4);
        check("t3_pend_clr", pend, 0);
        rti = 1'b1; tick(); rti = 1'b0;
        tick(); tick();

        // Enable low holds the request; enable drop in DRAIN returns to IDLE
        en  = 1'b0;
        req = 1'b1;
        repeat (L + 1) tick();
        check("t4_pend", pend, 1);
        repeat (3) begin
            tick();
            check("t4_dis_no_int", intr, 0);
            check("t4_dis_act", active, 0);
        end
        req  = 1'b0;
        en   = 1'b1;
        busy = 1'b1;
        tick();
        en = 1'b0;
        tick();
        check("t4_pend_kept", pend, 1);
        en   = 1'b1;
        busy = 1'b0;
        tick();
        check("t4_drain_no_int", intr, 0);
        tick();
        check("t4_intr", intr, 1);
        tick();
        check("t4_cnt", cnt, 5);
        rti = 1'b1; tick(); rti = 1'b0;
        tick(); tick();

        // Edge coincident with INJECT keeps pending
        busy = 1'b1;
        req  = 1'b1;
        repeat (L + 1) tick();
        req = 1'b0;
        repeat (3) tick();
`ifdef INTERRUPT_UNIT_SYNC_EN
        req = 1'b1;
        tick();
        busy = 1'b0;
        tick();
`else
        busy = 1'b0;
        tick();
        req = 1'b1;
`endif
        check("t5_intr", intr, 1);
        tick();
        check("t5_pend_kept", pend, 1);
        check("t5_cnt", cnt, 6);
        req = 1'b0;
        rti = 1'b1;
        tick();
        rti = 1'b0;
        repeat (3) begin
            tick();
            check("t5_hold_no_int", intr, 0);
        end
        tick();
        check("t5_intr2", intr, 1);
        tick();
        check("t5_cnt2", cnt, 7);
        rti = 1'b1; tick(); rti = 1'b0;
        tick(); tick();

        // Run count up to 255 in SERVICE, then async reset
        repeat (247) do_int();
        check("t6_cnt254", cnt, 254);
        req = 1'b1;
        repeat (L + 3) tick();
        req = 1'b0;
        check("t6_cnt255", cnt, 8'hFF);
        check("t6_svc_act", active, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_cnt",    cnt,    0);
        check("t6_rst_active", active, 0);
        check("t6_rst_intr",   intr,   0);
        check("t6_rst_flush",  flush,  0);
        check("t6_rst_pend",   pend,   0);
        tick();
        rst_n = 1'b1;
        tick();

        // 256 interrupts from reset wrap the counter
        for (int i = 0; i < 256; i++) begin
            do_int();
            if (i == 254) check("t7_cnt255", cnt, 255);
        end
        check("t7_wrap", cnt, 0);
        check("t7_idle", active, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
